// File: rtl/serial_word_tx.sv
// serial_word_tx
//
// Parallel-to-serial word transmitter feeding the single-bit input of the
// sequence detectors. Words are sent LSB first, one bit per clock. A word
// comes either from a valid/ready handshake (manual mode) or from a built-in
// ramp generator producing 0, STEP, 2*STEP, ... up to LIMIT (auto mode).
//
// Parameters:
//   WIDTH  bits per word
//   STEP   ramp increment in auto mode
//   LIMIT  last permitted ramp value (LIMIT < 2**WIDTH)
//
// Ports:
//   clk         clock, rising edge
//   rstn        asynchronous active-low reset
//   auto        source select (0 manual, 1 ramp), sampled in IDLE only
//   start       ramp start request, used when auto=1 in IDLE
//   data_in     word to transmit in manual mode
//   data_valid  data_in valid
//   data_ready  data_in accepted this cycle when data_valid is high
//   tx_bit      serial data (driven from registers only)
//   tx_valid    tx_bit carries a payload bit
//   word_done   current tx_bit is the last bit of a word
//   busy        transmitter is not idle
//   gen_done    one-cycle pulse after the final ramp word

module serial_word_tx #(
    parameter int WIDTH = 14,
    parameter int STEP  = 7,
    parameter int LIMIT = 500
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             auto,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx_bit,
    output logic             tx_valid,
    output logic             word_done,
    output logic             busy,
    output logic             gen_done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] rval;
    logic [BW-1:0]    bcnt;
    logic             amode;
    logic             gen_done_q;

    logic [WIDTH:0]   nxt;
    logic             ramp_ok;
    logic             last_bit;
    logic             load_word;
    logic             load_ramp_start;
    logic             load_ramp_next;
    logic             gen_done_set;

    // The extra top bit of nxt catches a carry out of WIDTH bits, which ends
    // the run exactly like exceeding LIMIT, so the ramp can never wrap.
    assign nxt      = {1'b0, rval} + (WIDTH + 1)'(STEP);
    assign ramp_ok  = !nxt[WIDTH] && (nxt <= (WIDTH + 1)'(LIMIT));
    assign last_bit = (state == SHIFT) && (bcnt == LAST_BIT);

    // All serial outputs are decoded from registered state only, so they
    // change exclusively on the rising clock edge and drop at once on reset.
    assign tx_bit    = (state == SHIFT) && shreg[0];
    assign tx_valid  = (state == SHIFT);
    assign word_done = last_bit;
    assign busy      = (state != IDLE);
    assign gen_done  = gen_done_q;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. In manual mode the next word is taken
    // on the last bit of the current one so consecutive words have no gap.
    always_comb begin
        state_next      = state;
        data_ready      = 1'b0;
        load_word       = 1'b0;
        load_ramp_start = 1'b0;
        load_ramp_next  = 1'b0;
        gen_done_set    = 1'b0;
        case (state)
            IDLE: begin
                data_ready = ~auto;
                if (!auto && data_valid) begin
                    load_word  = 1'b1;
                    state_next = SHIFT;
                end else if (auto && start) begin
                    load_ramp_start = 1'b1;
                    state_next      = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (!amode) begin
                        data_ready = 1'b1;
                        if (data_valid) begin
                            load_word = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else if (ramp_ok) begin
                        load_ramp_next = 1'b1;
                    end else begin
                        gen_done_set = 1'b1;
                        state_next   = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: shift register, bit counter, ramp value and latched mode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg      <= '0;
            rval       <= '0;
            bcnt       <= '0;
            amode      <= 1'b0;
            gen_done_q <= 1'b0;
        end else begin
            gen_done_q <= gen_done_set;
            if (load_word) begin
                shreg <= data_in;
                bcnt  <= '0;
                amode <= 1'b0;
            end else if (load_ramp_start) begin
                shreg <= '0;
                rval  <= '0;
                bcnt  <= '0;
                amode <= 1'b1;
            end else if (load_ramp_next) begin
                shreg <= nxt[WIDTH-1:0];
                rval  <= nxt[WIDTH-1:0];
                bcnt  <= '0;
            end else if (state == SHIFT) begin
                shreg <= shreg >> 1;
                bcnt  <= last_bit ? '0 : bcnt + 1'b1;
            end
        end
    end

endmodule
